// File: rtl/mul_trunc_pipe.sv
// mul_trunc_pipe: pipelined unsigned approximate multiplier with a per-transaction
// truncation column K. Partial products a_i&b_j with i+j < K are dropped, and an
// optional bias of 2^(K-1) compensates the average truncation error.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   in_valid/in_ready input handshake; A, B operands, in_trunc = K, in_comp = add bias
//   out_valid/out_ready output handshake; O = approximate product, out_trunc = clamped K
//
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
// Once out_valid rises, O/out_trunc hold until that transfer (or reset). in_ready is
// a combinational function of stage occupancy and out_ready.
//
// Structure: LAT register stages, each holding {valid, A, B, Kc, comp, acc}. Rows of the
// partial-product array are distributed evenly over the stages; each stage adds its rows
// to the running sum as it loads. The last stage also adds the bias and saturates, so O
// comes straight from registers.
module mul_trunc_pipe #(
  parameter int W   = 12,
  parameter int LAT = 3,
  localparam int TW = $clog2(2*W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [TW-1:0]    in_trunc,
  input  logic             in_comp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   O,
  output logic [TW-1:0]    out_trunc
);

  localparam int PW = 2*W + 1;                  // one spare bit to detect overflow
  localparam int RP = (W + LAT - 1) / LAT;      // partial-product rows per stage
  localparam logic [TW-1:0] KMAX = TW'(2*W - 1);

  logic [LAT-1:0] v_q, v_d;
  logic [LAT-1:0] move;                          // stage contents leave this cycle
  logic [LAT-1:0] load;                          // stage captures new contents this cycle

  logic [W-1:0]   a_q    [LAT];
  logic [W-1:0]   b_q    [LAT];
  logic [TW-1:0]  kc_q   [LAT];
  logic           comp_q [LAT];
  logic [PW-1:0]  acc_q  [LAT];

  logic [W-1:0]   a_d    [LAT];
  logic [W-1:0]   b_d    [LAT];
  logic [TW-1:0]  kc_d   [LAT];
  logic           comp_d [LAT];
  logic [PW-1:0]  acc_d  [LAT];

  // Row i of the partial-product array, keeping only columns i+j >= kc.
  function automatic logic [PW-1:0] row_term(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [TW-1:0] kc, input int i);
    logic [PW-1:0] t;
    t = '0;
    if (a[i]) begin
      for (int j = 0; j < W; j++) begin
        if (b[j] && (i + j >= int'(kc))) t[i+j] = 1'b1;
      end
    end
    return t;
  endfunction

  // Backward pass: a stage can move when the stage after it is empty or also moving.
  always_comb begin
    logic down_free;
    move      = '0;
    down_free = out_ready;
    for (int k = LAT - 1; k >= 0; k--) begin
      move[k]   = v_q[k] & down_free;
      down_free = ~v_q[k] | move[k];
    end
  end

  assign in_ready = ~v_q[0] | move[0];

  always_comb begin
    load    = '0;
    load[0] = in_valid & in_ready;
    for (int k = 1; k < LAT; k++) load[k] = move[k-1];
    v_d = load | (v_q & ~move);
  end

  // Datapath: what each stage would capture if it loads this cycle.
  always_comb begin
    logic [PW-1:0] sum;
    sum       = '0;
    a_d[0]    = A;
    b_d[0]    = B;
    kc_d[0]   = (in_trunc > KMAX) ? KMAX : in_trunc;
    comp_d[0] = in_comp;
    for (int k = 1; k < LAT; k++) begin
      a_d[k]    = a_q[k-1];
      b_d[k]    = b_q[k-1];
      kc_d[k]   = kc_q[k-1];
      comp_d[k] = comp_q[k-1];
    end
    for (int k = 0; k < LAT; k++) begin
      sum = (k == 0) ? '0 : acc_q[k-1];
      for (int i = 0; i < W; i++) begin
        if (i / RP == k) sum = sum + row_term(a_d[k], b_d[k], kc_d[k], i);
      end
      if (k == LAT - 1) begin
        if (comp_d[k] && (kc_d[k] != '0)) sum = sum + (PW'(1) << (kc_d[k] - TW'(1)));
        if (sum[2*W]) sum = {1'b0, {(2*W){1'b1}}};
      end
      acc_d[k] = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < LAT; k++) begin
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        kc_q[k]   <= '0;
        comp_q[k] <= 1'b0;
        acc_q[k]  <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < LAT; k++) begin
        if (load[k]) begin
          a_q[k]    <= a_d[k];
          b_q[k]    <= b_d[k];
          kc_q[k]   <= kc_d[k];
          comp_q[k] <= comp_d[k];
          acc_q[k]  <= acc_d[k];
        end
      end
    end
  end

  assign out_valid = v_q[LAT-1];
  assign O         = acc_q[LAT-1][2*W-1:0];
  assign out_trunc = kc_q[LAT-1];

endmodule
